// File: rtl/pipe_pkg.sv
// Shared pipeline types: forward-select codes, width defaults and the
// per-stage control bundle tracked through EX, MEM and WB.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
  } stage_ctl_t;

endpackage

// File: rtl/fwd_sel_gen.sv
// Operand forward-select comparator for one source register.
// Nearest producer wins; source x0 and unused sources select the regfile.
module fwd_sel_gen
  import pipe_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  stage_ctl_t        ex_ctl,
  input  stage_ctl_t        mem_ctl,
  output logic [1:0]        sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit = ex_ctl.valid
                & ex_ctl.reg_write
                & (ex_ctl.rd == src);

  assign mem_hit = mem_ctl.valid
                 & mem_ctl.reg_write
                 & (mem_ctl.rd == src);

  always_comb begin
    sel = FWD_REG;
    if (src_used && (src != '0)) begin
      if (ex_hit) begin
        sel = FWD_MEM;
      end else if (mem_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/ex_hazard_forward_ctrl.sv
// ID/EX register with load-use stall, branch flush and forward selects.
// HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt event counters.
module ex_hazard_forward_ctrl
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic              flush,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  stage_ctl_t ex_s;
  stage_ctl_t mem_s;
  stage_ctl_t wb_s;
  stage_ctl_t ex_nxt;

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       hz;
  logic       bubble;

  assign hz = ex_s.valid
            & ex_s.mem_read
            & (ex_s.rd != '0)
            & id_valid
            & ((id_rs1 == ex_s.rd)
               | (id_use_rs2 & (id_rs2 == ex_s.rd)));

  assign stall  = hz & ~flush;
  assign bubble = flush | hz;

  fwd_sel_gen #(.REG_AW(REG_AW)) u_fwd_a (
    .src      (id_rs1),
    .src_used (1'b1),
    .ex_ctl   (ex_s),
    .mem_ctl  (mem_s),
    .sel      (sel_a)
  );

  fwd_sel_gen #(.REG_AW(REG_AW)) u_fwd_b (
    .src      (id_rs2),
    .src_used (id_use_rs2),
    .ex_ctl   (ex_s),
    .mem_ctl  (mem_s),
    .sel      (sel_b)
  );

  // A bubble keeps rd but drops every control bit
  always_comb begin
    ex_nxt           = '0;
    ex_nxt.rd        = id_rd;
    if (!bubble) begin
      ex_nxt.valid     = id_valid;
      ex_nxt.reg_write = id_valid & id_reg_write;
      ex_nxt.mem_read  = id_valid & id_mem_read;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_s   <= '0;
      mem_s  <= '0;
      wb_s   <= '0;
      ex_rd1 <= '0;
      ex_rd2 <= '0;
      fwd_a  <= FWD_REG;
      fwd_b  <= FWD_REG;
    end else begin
      ex_s   <= ex_nxt;
      mem_s  <= ex_s;
      wb_s   <= mem_s;
      ex_rd1 <= id_rd1;
      ex_rd2 <= id_rd2;
      fwd_a  <= bubble ? FWD_REG : sel_a;
      fwd_b  <= bubble ? FWD_REG : sel_b;
    end
  end

  assign ex_valid     = ex_s.valid;
  assign ex_rd        = ex_s.rd;
  assign ex_reg_write = ex_s.reg_write;
  assign ex_mem_read  = ex_s.mem_read;

  // Write-back never carries a write from an empty slot
  a_wb_ctl: assert property (
    @(posedge clk) disable iff (!rst_n)
    wb_s.reg_write |-> wb_s.valid
  );

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (flush) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/ex_hazard_forward_ctrl.md
Name: ex_hazard_forward_ctrl

Overview:
- ID/EX pipeline register plus hazard controller for the 5-stage core.
- Registers decoded operands into EX and generates the 2-bit operand-select codes consumed by the EX-stage 3:1 operand muxes.
- Mux input mapping for those codes: 00 = register-file value, 01 = WB result, 10 = MEM result.
- Detects load-use hazards: stalls IF/ID and inserts EX bubbles. Also handles branch flush.
- Tracks destination info for the EX, MEM and WB stages in internal shadow registers.

Parameters:
- DATA_W, 32, operand width
- REG_AW, 5, register-address width; register 0 is hard-wired zero

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID slot holds a real instruction
- id_rs1  in  REG_AW  source register 1
- id_rs2  in  REG_AW  source register 2
- id_use_rs2  in  1  instruction reads rs2 (0 for immediate forms)
- id_rd  in  REG_AW  destination register
- id_reg_write  in  1  instruction writes rd
- id_mem_read  in  1  instruction is a load
- id_rd1  in  DATA_W  register-file read data 1
- id_rd2  in  DATA_W  register-file read data 2
- flush  in  1  taken branch resolved in EX; kill ID slot
- ex_valid  out  1  EX slot valid
- ex_rd1  out  DATA_W  registered operand A
- ex_rd2  out  DATA_W  registered operand B
- ex_rd  out  REG_AW  registered destination
- ex_reg_write  out  1  registered write enable (0 in a bubble)
- ex_mem_read  out  1  registered load flag (0 in a bubble)
- fwd_a  out  2  select for operand-A mux
- fwd_b  out  2  select for operand-B mux
- stall  out  1  combinational; hold PC and IF/ID this cycle

Behaviour:
- Reset: all registered outputs 0; fwd_a/fwd_b = 00; ex_valid = 0. Internal mem/wb shadows cleared (valid = 0, rd = 0, reg_write = 0). Reset is asynchronous and may assert mid-stall; the first cycle after release shows stall = 0.
- Shadow pipeline advances every clock; MEM and WB never stall:
  - mem_* <= ex_*
  - wb_* <= mem_*
- Load-use hazard, combinational:
  - hz = ex_valid & ex_mem_read & (ex_rd != 0) & id_valid & ((id_rs1 == ex_rd) | (id_use_rs2 & (id_rs2 == ex_rd)))
  - stall = hz & ~flush
- Per clock, priority order:
  1. flush: EX loads a bubble (valid, reg_write, mem_read = 0; fwd = 00); stall = 0.
  2. hz: EX loads a bubble. The ID instruction is re-presented next cycle, when the load sits in MEM.
  3. Otherwise: EX loads all id_* fields.
- Forward select, computed for the ID instruction as it enters EX, then registered:
  - 10 if the current EX slot is valid, reg_write, rd != 0 and rd matches the source.
  - Else 01 if the current MEM shadow matches under the same conditions.
  - Else 00.
  - Most recent producer wins when both match.
  - rs2 select is 00 when id_use_rs2 = 0.
  - Source 0 always yields 00.
- Register file is write-before-read. A WB-stage write in the same cycle as the ID read needs no forwarding.
- Latency: one cycle from ID inputs to ex_* outputs.
- Data fields are not cleared in a bubble; only control bits are.
- Back-to-back loads with dependents stall exactly one cycle each.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined: adds output ports stall_cnt (32) and flush_cnt (32), reset to 0. stall_cnt increments once per cycle with stall = 1; flush_cnt increments once per cycle with flush = 1. Both wrap at 2^32 - 1 to 0.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - FWD_REG = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10
  - REG_AW and DATA_W defaults
  - stage-control struct {valid, rd, reg_write, mem_read}
- One natural sub-module, fwd_sel_gen: purely combinational comparator producing one 2-bit select. Instantiated twice, once each for rs1 and rs2.

Test Plan:
- add x3 then add x4,x3,x1 back-to-back -> second instruction in EX shows fwd_a = 10, stall never asserted.
- add x3, nop, sub x5,x1,x3 -> sub in EX shows fwd_b = 01 with id_use_rs2 = 1; with id_use_rs2 = 0 it shows fwd_b = 00.
- lw x7, then add x8,x7,x2 -> stall = 1 for exactly one cycle and ex_valid = 0 (bubble). Next cycle add in EX shows fwd_a = 01.
- lw x7 followed by dependent, with flush = 1 in the hazard cycle -> stall = 0, bubble in EX; with HAZ_PERF_CNT_EN, flush_cnt = 1 and stall_cnt = 0.
- Writes to x0 followed by a reader of x0 -> fwd = 00, no stall, even when the producer is a load.
- rst_n dropped asynchronously during a stall -> ex_valid, stall and fwd_* go to 0 immediately; the first instruction after release latches normally.
